coin_acceptor: RTL and testbench

Front-end stage of the newspaper vending machine. It synchronises and debounces the two raw coin-slot sensors (5 fen, 10 fen) and turns each accepted coin into exactly one single-cycle `coinin` code for the vending FSM. Coins that arrive while the FSM is still being fed are held in a small queue. Coins that cannot be accepted are signalled for return on `reject`.

---
 rtl/coin_pkg.sv | 16 +
 rtl/coin_debounce.sv | 48 ++++
 rtl/coin_acceptor.sv | 146 ++++++++++++++
 tb/tb_coin_acceptor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes and emitter state encoding for the coin acceptor front end.
package coin_pkg;

   typedef logic [1:0] coin_t;

   localparam coin_t COIN_NONE = 2'b00;
   localparam coin_t COIN_5    = 2'b01;
   localparam coin_t COIN_10   = 2'b10;

   typedef enum logic [1:0] {
      EM_IDLE = 2'b00,
      EM_EMIT = 2'b01,
      EM_GAP  = 2'b10
   } emit_state_e;

endpackage

// File: rtl/coin_debounce.sv
// One coin-slot channel: 2-flop synchroniser, level debouncer and a
// single-cycle pulse on each accepted rising edge of the debounced level.
module coin_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_rise
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic             r_meta;
   logic             r_sync;
   logic             r_deb;
   logic [CNT_W-1:0] r_cnt;
   logic             r_rise;

   // The flip cycle doubles as the edge detector, so the pulse needs no extra flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_deb  <= 1'b0;
         r_cnt  <= '0;
         r_rise <= 1'b0;
      end else begin
         r_meta <= i_raw;
         r_sync <= r_meta;
         r_rise <= 1'b0;
         if (r_sync != r_deb) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               r_deb  <= r_sync;
               r_cnt  <= '0;
               r_rise <= r_sync;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces both slots, queues accepted coins and feeds them to
// the vending FSM as spaced single-cycle codes; unacceptable coins pulse reject.
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned GAP_CYCLES      = 2,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin5_raw,
   input  logic       coin10_raw,
   input  logic       accept_en,
   output logic [1:0] coinin,
   output logic       reject,
   output logic       busy
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

   logic              w_rise5;
   logic              w_rise10;

   coin_t             r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr;
   logic [PTR_W-1:0]  r_rd;
   logic [CNT_W-1:0]  r_count;

   emit_state_e       r_state;
   emit_state_e       w_state_nxt;
   logic [GAP_W-1:0]  r_gap;
   logic [GAP_W-1:0]  w_gap_nxt;
   coin_t             r_coinin;
   coin_t             w_coinin_nxt;
   logic              r_reject;
   logic              r_busy;

   logic [CNT_W-1:0]  w_free;
   logic              w_push5;
   logic              w_push10;
   logic              w_pop;
   logic              w_reject_nxt;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [PTR_W-1:0]  w_wr10;
   logic              w_busy_nxt;

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (coin5_raw),
      .o_rise (w_rise5)
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (coin10_raw),
      .o_rise (w_rise10)
   );

   // Admission: slots free at the start of the cycle only; 5 fen wins a single slot.
   always_comb begin
      w_free       = CNT_W'(FIFO_DEPTH) - r_count;
      w_push5      = accept_en && w_rise5 && (w_free != '0);
      w_push10     = accept_en && w_rise10 && (w_free > CNT_W'(w_push5));
      w_reject_nxt = (w_rise5 && !w_push5) || (w_rise10 && !w_push10);
      w_wr10       = r_wr + PTR_W'(w_push5);
      w_count_nxt  = r_count + CNT_W'(w_push5) + CNT_W'(w_push10) - CNT_W'(w_pop);
   end

   // Emitter next-state and next-output.
   always_comb begin
      w_state_nxt  = r_state;
      w_gap_nxt    = r_gap;
      w_coinin_nxt = COIN_NONE;
      w_pop        = 1'b0;
      case (r_state)
         EM_IDLE: begin
            if (r_count != '0) begin
               w_pop        = 1'b1;
               w_coinin_nxt = r_mem[r_rd];
               w_state_nxt  = EM_EMIT;
            end
         end
         EM_EMIT: begin
            w_gap_nxt   = '0;
            w_state_nxt = EM_GAP;
         end
         EM_GAP: begin
            if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
               if (r_count != '0) begin
                  w_pop        = 1'b1;
                  w_coinin_nxt = r_mem[r_rd];
                  w_state_nxt  = EM_EMIT;
               end else begin
                  w_state_nxt = EM_IDLE;
               end
            end else begin
               w_gap_nxt = r_gap + GAP_W'(1);
            end
         end
         default: w_state_nxt = EM_IDLE;
      endcase
      w_busy_nxt = (w_count_nxt != '0) || (w_state_nxt != EM_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr     <= '0;
         r_rd     <= '0;
         r_count  <= '0;
         r_state  <= EM_IDLE;
         r_gap    <= '0;
         r_coinin <= COIN_NONE;
         r_reject <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_wr     <= w_wr10 + PTR_W'(w_push10);
         r_rd     <= r_rd + PTR_W'(w_pop);
         r_count  <= w_count_nxt;
         r_state  <= w_state_nxt;
         r_gap    <= w_gap_nxt;
         r_coinin <= w_coinin_nxt;
         r_reject <= w_reject_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   // Queue storage; contents are only meaningful below r_count.
   always_ff @(posedge clk) begin
      if (w_push5) begin
         r_mem[r_wr] <= COIN_5;
      end
      if (w_push10) begin
         r_mem[w_wr10] <= COIN_10;
      end
   end

   assign coinin = r_coinin;
   assign reject = r_reject;
   assign busy   = r_busy;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with a short debounce and a long gap so the
// queue can be overfilled by coin pairs while the emitter drains.
module tb_coin_acceptor;

   localparam int unsigned D = 4;
   localparam int unsigned G = 20;
   localparam int unsigned F = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin5_raw;
   logic       coin10_raw;
   logic       accept_en;
   logic [1:0] coinin;
   logic       reject;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;
   int n5 = 0;
   int n10 = 0;
   int n_rej = 0;
   int n_busy = 0;

   coin_acceptor #(
      .DEBOUNCE_CYCLES(D),
      .GAP_CYCLES     (G),
      .FIFO_DEPTH     (F)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .coin5_raw  (coin5_raw),
      .coin10_raw (coin10_raw),
      .accept_en  (accept_en),
      .coinin     (coinin),
      .reject     (reject),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, sample 1 ns later and tally what the DUT produced.
   task automatic tick();
      @(posedge clk);
      #1;
      if (coinin == 2'b01) n5++;
      if (coinin == 2'b10) n10++;
      if (reject) n_rej++;
      if (busy) n_busy++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int zeros;
      int rej0;
      int busy0;
      int cnt0;

      rst        = 1'b1;
      coin5_raw  = 1'b0;
      coin10_raw = 1'b0;
      accept_en  = 1'b1;
      #12;
      check("reset_coinin", 32'(coinin), 32'd0);
      check("reset_reject", 32'(reject), 32'd0);
      check("reset_busy",   32'(busy),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      ticks(3);

      // Clean 5-fen step: code after edge D+4 = 8 for one cycle.
      coin5_raw = 1'b1;
      ticks(7);
      check("t1_before", 32'(coinin), 32'd0);
      tick();
      check("t1_code", 32'(coinin), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      tick();
      check("t1_after", 32'(coinin), 32'd0);
      coin5_raw = 1'b0;
      ticks(30);
      check("t1_count5", 32'(n5), 32'd1);
      check("t1_noreject", 32'(n_rej), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);

      // 10-fen bounce with 3-cycle pulses, then a steady hold.
      repeat (3) begin
         coin10_raw = 1'b1;
         ticks(3);
         coin10_raw = 1'b0;
         ticks(3);
      end
      check("t2_bounce", 32'(n10), 32'd0);
      coin10_raw = 1'b1;
      ticks(12);
      coin10_raw = 1'b0;
      ticks(30);
      check("t2_count10", 32'(n10), 32'd1);
      check("t2_noreject", 32'(n_rej), 32'd0);

      // Simultaneous rise: 01, G idle cycles, then 10.
      coin5_raw  = 1'b1;
      coin10_raw = 1'b1;
      ticks(7);
      check("t3_before", 32'(coinin), 32'd0);
      tick();
      check("t3_code5", 32'(coinin), 32'd1);
      zeros = 0;
      repeat (G) begin
         tick();
         if (coinin == 2'b00) zeros++;
      end
      check("t3_gap", 32'(zeros), 32'(G));
      tick();
      check("t3_code10", 32'(coinin), 32'd2);
      tick();
      check("t3_after", 32'(coinin), 32'd0);
      coin5_raw  = 1'b0;
      coin10_raw = 1'b0;
      ticks(30);
      check("t3_noreject", 32'(n_rej), 32'd0);

      // Three pairs 10 cycles apart: only one pop fits before the third pair,
      // so its 10-fen coin (the 6th) finds the queue full.
      repeat (3) begin
         coin5_raw  = 1'b1;
         coin10_raw = 1'b1;
         ticks(5);
         coin5_raw  = 1'b0;
         coin10_raw = 1'b0;
         ticks(5);
      end
      check("t4_reject", 32'(n_rej), 32'd1);
      ticks(150);
      check("t4_count5", 32'(n5), 32'd5);
      check("t4_count10", 32'(n10), 32'd4);
      check("t4_idle", 32'(busy), 32'd0);

      // Acceptance disabled: reject after edge D+3 = 7, nothing else.
      accept_en = 1'b0;
      rej0  = n_rej;
      busy0 = n_busy;
      cnt0  = n5 + n10;
      coin5_raw = 1'b1;
      ticks(6);
      check("t5_before", 32'(reject), 32'd0);
      tick();
      check("t5_reject", 32'(reject), 32'd1);
      tick();
      check("t5_after", 32'(reject), 32'd0);
      coin5_raw = 1'b0;
      ticks(20);
      check("t5_one_pulse", 32'(n_rej - rej0), 32'd1);
      check("t5_no_code", 32'(n5 + n10 - cnt0), 32'd0);
      check("t5_no_busy", 32'(n_busy - busy0), 32'd0);
      accept_en = 1'b1;

      // Queue three coins, then reset asynchronously mid-cycle.
      coin5_raw  = 1'b1;
      coin10_raw = 1'b1;
      ticks(5);
      coin5_raw  = 1'b0;
      coin10_raw = 1'b0;
      ticks(5);
      coin5_raw  = 1'b1;
      coin10_raw = 1'b1;
      ticks(5);
      coin5_raw  = 1'b0;
      coin10_raw = 1'b0;
      ticks(3);
      check("t6_busy_before", 32'(busy), 32'd1);
      cnt0 = n5 + n10;
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_coinin", 32'(coinin), 32'd0);
      check("t6_rst_reject", 32'(reject), 32'd0);
      check("t6_rst_busy",   32'(busy),   32'd0);
      ticks(3);
      @(negedge clk);
      rst = 1'b0;
      ticks(60);
      check("t6_no_emit", 32'(n5 + n10), 32'(cnt0));
      check("t6_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
